// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver, LSB first, with a one-deep registered output holding stage.
// Optional even-parity bit after each word when SERIAL_WORD_RX_PARITY_EN is defined.
module serial_word_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ct,
    input  logic             in,
    input  logic             in_vld,
    output logic [WIDTH-1:0] out_word,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             ovf,
    output logic             perr,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef SERIAL_WORD_RX_PARITY_EN
        PAR   = 2'd2,
`endif
        SHIFT = 2'd1
    } state_t;

    state_t           state_r, state_n;
    logic [CW-1:0]    cnt_r, cnt_n;
    logic [WIDTH-1:0] sh_r, sh_n;
    logic [WIDTH-1:0] word_s;
    logic             done_s;

`ifdef SERIAL_WORD_RX_PARITY_EN
    logic             perr_s;
    logic             perr_r;

    // Even parity holds when data bits and parity bit XOR to zero.
    function automatic logic even_ok(input logic [WIDTH-1:0] d, input logic p);
        return ~((^d) ^ p);
    endfunction
`endif

    // State, bit counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            sh_r    <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            sh_r    <= sh_n;
        end
    end

    // Next-state logic; ct wins over any bit presented in the same cycle.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        sh_n    = sh_r;
        word_s  = sh_r;
        done_s  = 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
        perr_s  = 1'b0;
`endif
        if (ct) begin
            state_n = IDLE;
            cnt_n   = {CW{1'b0}};
            sh_n    = {WIDTH{1'b0}};
        end else if (in_vld) begin
            case (state_r)
                IDLE, SHIFT: begin
                    sh_n[cnt_r] = in;
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        cnt_n = {CW{1'b0}};
`ifdef SERIAL_WORD_RX_PARITY_EN
                        state_n = PAR;
`else
                        state_n = IDLE;
                        done_s  = 1'b1;
                        word_s  = sh_n;
                        sh_n    = {WIDTH{1'b0}};
`endif
                    end else begin
                        cnt_n   = cnt_r + CW'(1);
                        state_n = SHIFT;
                    end
                end
`ifdef SERIAL_WORD_RX_PARITY_EN
                PAR: begin
                    state_n = IDLE;
                    sh_n    = {WIDTH{1'b0}};
                    if (even_ok(sh_r, in)) begin
                        done_s = 1'b1;
                    end else begin
                        perr_s = 1'b1;
                    end
                end
`endif
                default: begin
                    state_n = IDLE;
                    cnt_n   = {CW{1'b0}};
                    sh_n    = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Output holding stage: load when empty or retiring, otherwise drop and flag overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word <= {WIDTH{1'b0}};
            out_vld  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (done_s) begin
                if (!out_vld || out_rdy) begin
                    out_word <= word_s;
                    out_vld  <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end else begin
                out_vld <= out_vld;
            end
        end
    end

`ifdef SERIAL_WORD_RX_PARITY_EN
    // One-cycle parity error pulse following a bad parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_r <= 1'b0;
        end else begin
            perr_r <= perr_s;
        end
    end
    assign perr = perr_r;
`else
    assign perr = 1'b0;
`endif

    assign busy = (state_r != IDLE);
endmodule

// File: tb/tb_serial_word_rx.sv
// Randomized and directed bench for serial_word_rx (WIDTH=8) against a bit-count/accumulator model.
module tb_serial_word_rx;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ct = 1'b0;
    logic         in = 1'b0;
    logic         in_vld = 1'b0;
    logic         out_rdy = 1'b0;
    logic [W-1:0] out_word;
    logic         out_vld;
    logic         ovf;
    logic         perr;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    int           m_nb;
    logic [31:0]  m_acc;
    logic         m_vld;
    logic [W-1:0] m_word;
    logic         m_ovf;
    logic         m_perr;

    serial_word_rx #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ct(ct), .in(in), .in_vld(in_vld),
        .out_word(out_word), .out_vld(out_vld), .out_rdy(out_rdy),
        .ovf(ovf), .perr(perr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_nb = 0; m_acc = 32'd0; m_vld = 1'b0; m_word = '0; m_ovf = 1'b0; m_perr = 1'b0;
    endtask

    // Reference: bits accumulate arithmetically; a word is done after W bits (plus parity if enabled).
    task automatic model_step(input logic v, input logic b, input logic c, input logic r);
        logic         done;
        logic [W-1:0] w;
        done = 1'b0; w = '0; m_perr = 1'b0;
        if (c) begin
            m_nb = 0; m_acc = 32'd0;
        end else if (v) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
            if (m_nb == W) begin
                if ((($countones(m_acc) + int'(b)) % 2) == 0) begin
                    done = 1'b1; w = m_acc[W-1:0];
                end else begin
                    m_perr = 1'b1;
                end
                m_nb = 0; m_acc = 32'd0;
            end else begin
                m_acc = m_acc + (32'(b) << m_nb);
                m_nb++;
            end
`else
            m_acc = m_acc + (32'(b) << m_nb);
            m_nb++;
            if (m_nb == W) begin
                done = 1'b1; w = m_acc[W-1:0]; m_nb = 0; m_acc = 32'd0;
            end
`endif
        end
        if (done) begin
            if (!m_vld || r) begin
                m_word = w; m_vld = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_vld && r) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic cycle(input logic v, input logic b, input logic c, input logic r);
        in_vld = v; in = b; ct = c; out_rdy = r;
        @(posedge clk);
        model_step(v, b, c, r);
        #1;
        chk("out_vld", 32'(out_vld), 32'(m_vld));
        chk("out_word", 32'(out_word), 32'(m_word));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("perr", 32'(perr), 32'(m_perr));
        chk("busy", 32'(busy), 32'(m_nb != 0));
    endtask

    task automatic send(input logic [31:0] val, input int n, input logic r, input logic r_last);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, val[i], 1'b0, (i == n - 1) ? r_last : r);
        end
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset out_vld", 32'(out_vld), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bits 1,0,1,0,0,1,0,1 -> 0xA5 one cycle later, gone the cycle after.
        send(32'h0000_00A5, W, 1'b1, 1'b1);
        chk("a5 vld", 32'(out_vld), 32'd1);
        chk("a5 word", 32'(out_word), 32'h0000_00A5);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("a5 one cycle", 32'(out_vld), 32'd0);

        // Partial 0xFF cut by ct, then 0x3C.
        send(32'h0000_00FF, 3, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("ct clears busy", 32'(busy), 32'd0);
        chk("ct no word", 32'(out_vld), 32'd0);
        send(32'h0000_003C, W, 1'b1, 1'b1);
        chk("3c word", 32'(out_word), 32'h0000_003C);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // 0x55 held, 0x66 completes while retiring.
        send(32'h0000_0055, W, 1'b0, 1'b0);
        send(32'h0000_0066, W, 1'b0, 1'b1);
        chk("66 word", 32'(out_word), 32'h0000_0066);
        chk("66 vld", 32'(out_vld), 32'd1);
        chk("66 ovf", 32'(ovf), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Overflow: 0x11 held, 0x22 dropped.
        send(32'h0000_0011, W, 1'b0, 1'b0);
        send(32'h0000_0022, W, 1'b0, 1'b0);
        chk("ovf set", 32'(ovf), 32'd1);
        chk("11 kept", 32'(out_word), 32'h0000_0011);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("11 retired", 32'(out_vld), 32'd0);
        chk("ovf sticky", 32'(ovf), 32'd1);

        // Async reset mid-word, then 0xC3.
        send(32'h0000_000F, 4, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst out_word", 32'(out_word), 32'd0);
        chk("rst out_vld", 32'(out_vld), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst perr", 32'(perr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h0000_00C3, W, 1'b1, 1'b1);
        chk("c3 word", 32'(out_word), 32'h0000_00C3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_WORD_RX_PARITY_EN
        send(32'h0000_0007, W, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        chk("par ok vld", 32'(out_vld), 32'd1);
        chk("par ok word", 32'(out_word), 32'h0000_0007);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        send(32'h0000_0007, W, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        chk("par bad perr", 32'(perr), 32'd1);
        chk("par bad vld", 32'(out_vld), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("perr one cycle", 32'(perr), 32'd0);
`endif

        // Random traffic checked every cycle against the model.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per word (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ct  input  1  frame clear/sync from the serial sender.
REQ-005 SHALL have port in  input  1  serial data bit, LSB first.
REQ-006 SHALL have port in_vld  input  1  qualifies in for the current cycle.
REQ-007 SHALL have port out_word  output  WIDTH  assembled word, registered.
REQ-008 SHALL have port out_vld  output  1  out_word holds an undelivered word.
REQ-009 SHALL have port out_rdy  input  1  downstream accepts out_word when high with out_vld.
REQ-010 SHALL have port ovf  output  1  sticky overflow flag: a completed word was dropped.
REQ-011 SHALL have port perr  output  1  one-cycle parity-error pulse.
REQ-012 SHALL have port busy  output  1  high while a word is partially received.

Function
REQ-013 SHALL implement FSM states IDLE (no bits held), SHIFT (1..WIDTH-1 bits held) and, per REQ-028, PAR; busy = (state != IDLE).
REQ-014 SHALL accept a bit only on a cycle where in_vld=1 and ct=0; with in_vld=0 all state holds.
REQ-015 SHALL write an accepted bit at index cnt of the shift register, then increment cnt; IDLE->SHIFT on the first bit.
REQ-016 SHALL treat the WIDTH-th accepted bit as word completion: cnt returns to 0 and state returns to IDLE.
REQ-017 SHALL, when ct=1, clear the shift register and cnt to 0 and enter IDLE next cycle; ct takes priority over a simultaneous in_vld, whose bit is discarded.
REQ-018 SHALL leave out_word, out_vld and ovf unaffected by ct.
REQ-019 SHALL load a completed word into out_word with out_vld=1 on the cycle after the completing bit (latency 1).
REQ-020 SHALL retire the held word on any cycle with out_vld=1 and out_rdy=1; out_vld falls next cycle unless a new word loads that same cycle.
REQ-021 SHALL load a word completing in the same cycle as a retirement without loss and without setting ovf.
REQ-022 SHALL, when a word completes while out_vld=1 and out_rdy=0, drop the new word, keep out_word unchanged and set ovf=1 next cycle.
REQ-023 SHALL hold out_word stable while out_vld=1 and not retired.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-word, asynchronously clear state to IDLE and clear cnt, shift register, out_word, out_vld, ovf, perr and busy to 0.
REQ-025 SHALL clear ovf only via reset.
REQ-026 SHALL resume normal reception on the first clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL use macro SERIAL_WORD_RX_PARITY_EN.
REQ-028 SHALL, with SERIAL_WORD_RX_PARITY_EN defined, enter PAR after the WIDTH-th data bit instead of completing, and treat the next accepted bit as an even-parity bit; ct in PAR behaves per REQ-017.
REQ-029 SHALL, with the macro defined, complete the word on the parity bit when the XOR of the data and parity bits is 0; otherwise it SHALL discard the word, pulse perr for exactly one cycle after the parity bit, and leave out_vld and ovf unaffected.
REQ-030 SHALL, without the macro, omit the PAR state and parity logic and tie perr to 0.

Verification (WIDTH=8)
REQ-031 SHALL test: bits 1,0,1,0,0,1,0,1 with in_vld=1 and out_rdy=1 -> out_vld=1 for one cycle, one cycle after the 8th bit, with out_word=0xA5.
REQ-032 SHALL test: three bits of 0xFF, then ct=1 for one cycle, then a full 0x3C -> exactly one word is delivered: 0x3C.
REQ-033 SHALL test: out_rdy=0 while 0x11 then 0x22 are sent -> out_word stays 0x11 and ovf=1 one cycle after 0x22 completes; raising out_rdy delivers only 0x11.
REQ-034 SHALL test: 0x55 held with out_vld=1, 0x66 completes in the same cycle out_rdy=1 -> out_word=0x66 next cycle, out_vld stays 1, ovf=0.
REQ-035 SHALL test, with the macro defined: 0x07 then parity bit 1 -> 0x07 delivered; 0x07 then parity bit 0 -> perr pulses once, no out_vld.
REQ-036 SHALL test: rst_n low after 4 bits of a word -> all outputs 0; the next 8 bits 0xC3 -> out_word=0xC3.
